// File: rtl/keystone_coeff_scheduler_if.sv
// keystone_coeff_scheduler_if
//   Groups the host configuration strobes, the passive stream monitor taps and the core
//   control outputs of the keystone coefficient scheduler into one bundle.
// Signals
//   cfg_wr_en/cfg_wr_addr/cfg_wr_data  staging register write port (addr 0..8 = H11..H33)
//   commit, enable_req                 host apply request pulse / run level
//   mon_tvalid/tready/tuser/tlast      core input stream taps (observed only)
//   coeff_out                          active H11..H33, H11 in the low word
//   core_enable, core_sw_reset         core clock enable / soft reset
//   pending, applied, stall_err        status
// Modports: master = host/stream side, slave = scheduler.
interface keystone_coeff_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    cfg_wr_en;
  logic [3:0]              cfg_wr_addr;
  logic [DATA_WIDTH-1:0]   cfg_wr_data;
  logic                    commit;
  logic                    enable_req;
  logic                    mon_tvalid;
  logic                    mon_tready;
  logic                    mon_tuser;
  logic                    mon_tlast;
  logic [9*DATA_WIDTH-1:0] coeff_out;
  logic                    core_enable;
  logic                    core_sw_reset;
  logic                    pending;
  logic                    applied;
  logic                    stall_err;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, commit, enable_req,
    output mon_tvalid, mon_tready, mon_tuser, mon_tlast,
    input  coeff_out, core_enable, core_sw_reset, pending, applied, stall_err
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, commit, enable_req,
    input  mon_tvalid, mon_tready, mon_tuser, mon_tlast,
    output coeff_out, core_enable, core_sw_reset, pending, applied, stall_err
  );
endinterface

// File: rtl/keystone_coeff_scheduler.sv
// keystone_coeff_scheduler
//   Holds staging copies of the nine homography coefficients and moves them to the active set
//   only at frame boundaries (or whenever the core is not running). Sequences core power-up:
//   timed soft reset, then clock enable. Tracks frame position from the monitored stream and
//   flags a stream that stalls mid-frame.
// Ports
//   i_clock  sole clock
//   i_reset  asynchronous, active-high reset
//   bus      keystone_coeff_scheduler_if.slave (config, monitor taps, core control, status)
module keystone_coeff_scheduler #(
  parameter int unsigned              DATA_WIDTH      = 32,
  parameter int unsigned              LINES_PER_FRAME = 720,
  parameter int unsigned              RESET_CYCLES    = 4,
  parameter int unsigned              IDLE_TIMEOUT    = 1024,
  parameter logic [DATA_WIDTH-1:0]    COEFF_ONE       = 32'h0001_0000
) (
  input logic                        i_clock,
  input logic                        i_reset,
  keystone_coeff_scheduler_if.slave  bus
);

  localparam int unsigned LineW = $clog2(LINES_PER_FRAME + 1);
  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned RstW  = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {StOff, StResetting, StRun} state_e;

  // Identity homography: ones on the diagonal (H11, H22, H33).
  function automatic logic [DATA_WIDTH-1:0] identity_coeff(input int idx);
    return (idx == 0 || idx == 4 || idx == 8) ? COEFF_ONE : '0;
  endfunction

  logic [DATA_WIDTH-1:0] r_stage [9];
  logic [DATA_WIDTH-1:0] r_coeff [9];
  logic                  r_pending;
  logic                  r_applied;
  logic [LineW-1:0]      r_line_cnt;
  logic [IdleW-1:0]      r_idle_cnt;
  logic                  r_mid_frame;
  logic                  r_stall_err;
  state_e                r_state;
  logic [RstW-1:0]       r_rst_cnt;
  logic                  r_core_enable;
  logic                  r_core_sw_reset;

  logic             w_beat;
  logic [LineW-1:0] w_line_base;
  logic             w_frame_end;
  logic             w_timeout;
  logic             w_apply;

  assign w_beat      = bus.mon_tvalid & bus.mon_tready;
  // tuser resyncs the line count before this beat's tlast is counted.
  assign w_line_base = bus.mon_tuser ? '0 : r_line_cnt;
  assign w_frame_end = w_beat & bus.mon_tlast & (w_line_base == LineW'(LINES_PER_FRAME - 1));
  assign w_timeout   = ~w_beat & r_mid_frame & (r_idle_cnt == IdleW'(IDLE_TIMEOUT - 1));
  // A beat while not mid-frame starts a new frame, which must run on the old set.
  assign w_apply     = r_pending &
                       ((r_state != StRun) | (~r_mid_frame & ~w_beat) | w_frame_end);

  // Staging, active set and commit handshake.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 9; i++) begin
        r_stage[i] <= identity_coeff(i);
        r_coeff[i] <= identity_coeff(i);
      end
      r_pending <= 1'b0;
      r_applied <= 1'b0;
    end else begin
      r_applied <= w_apply;
      if (w_apply) begin
        for (int i = 0; i < 9; i++) r_coeff[i] <= r_stage[i];
        r_pending <= 1'b0;
      end else if (bus.commit) begin
        r_pending <= 1'b1;
      end
      if (bus.cfg_wr_en && (bus.cfg_wr_addr < 4'd9)) begin
        r_stage[bus.cfg_wr_addr] <= bus.cfg_wr_data;
      end
    end
  end

  // Frame position and stall detection.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_line_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_mid_frame <= 1'b0;
      r_stall_err <= 1'b0;
    end else if (w_beat) begin
      r_idle_cnt  <= '0;
      r_mid_frame <= 1'b1;
      if (bus.mon_tlast) begin
        if (w_frame_end) begin
          r_line_cnt  <= '0;
          r_mid_frame <= 1'b0;
        end else begin
          r_line_cnt <= w_line_base + LineW'(1);
        end
      end else begin
        r_line_cnt <= w_line_base;
      end
    end else begin
      if (w_timeout) begin
        r_mid_frame <= 1'b0;
        r_line_cnt  <= '0;
        r_stall_err <= 1'b1;
      end
      if (r_idle_cnt != IdleW'(IDLE_TIMEOUT - 1)) r_idle_cnt <= r_idle_cnt + IdleW'(1);
    end
  end

  // Core power sequencing; dropping enable_req wins over every other transition.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= StOff;
      r_rst_cnt       <= '0;
      r_core_enable   <= 1'b0;
      r_core_sw_reset <= 1'b1;
    end else if (!bus.enable_req) begin
      r_state         <= StOff;
      r_core_enable   <= 1'b0;
      r_core_sw_reset <= 1'b1;
    end else begin
      case (r_state)
        StOff: begin
          r_state         <= StResetting;
          r_rst_cnt       <= '0;
          r_core_enable   <= 1'b0;
          r_core_sw_reset <= 1'b1;
        end
        StResetting: begin
          if (r_rst_cnt == RstW'(RESET_CYCLES - 1)) begin
            r_state         <= StRun;
            r_core_enable   <= 1'b1;
            r_core_sw_reset <= 1'b0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RstW'(1);
          end
        end
        StRun: begin
          r_core_enable   <= 1'b1;
          r_core_sw_reset <= 1'b0;
        end
        default: begin
          r_state         <= StOff;
          r_core_enable   <= 1'b0;
          r_core_sw_reset <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_coeff_out
    assign bus.coeff_out[g*DATA_WIDTH +: DATA_WIDTH] = r_coeff[g];
  end

  assign bus.core_enable   = r_core_enable;
  assign bus.core_sw_reset = r_core_sw_reset;
  assign bus.pending       = r_pending;
  assign bus.applied       = r_applied;
  assign bus.stall_err     = r_stall_err;

endmodule

// File: tb/tb_keystone_coeff_scheduler.sv
// Self-checking bench for keystone_coeff_scheduler: directed scenarios with literal expectations
// followed by randomized stream/config traffic, all checked every cycle against a behavioural model.
module tb_keystone_coeff_scheduler;
  localparam int unsigned DW  = 32;
  localparam int unsigned LPF = 720;
  localparam int unsigned RC  = 4;
  localparam int unsigned IT  = 1024;
  localparam logic [DW-1:0] ONE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keystone_coeff_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  keystone_coeff_scheduler #(
    .DATA_WIDTH(DW), .LINES_PER_FRAME(LPF), .RESET_CYCLES(RC), .IDLE_TIMEOUT(IT), .COEFF_ONE(ONE)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] pack9(input logic [DW-1:0] a [9]);
    logic [9*DW-1:0] r;
    for (int i = 0; i < 9; i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  // Mode: 0 = off, 1 = soft reset in progress, 2 = running.
  int              m_mode, m_rcnt, m_line, m_idle;
  bit              m_mid, m_stall, m_pending, m_applied;
  logic [DW-1:0]   m_stage [9];
  logic [DW-1:0]   m_coeff [9];

  function automatic void m_reset();
    for (int i = 0; i < 9; i++) begin
      m_stage[i] = (i % 4 == 0) ? ONE : '0;
      m_coeff[i] = m_stage[i];
    end
    m_mode = 0; m_rcnt = 0; m_line = 0; m_idle = 0;
    m_mid = 0; m_stall = 0; m_pending = 0; m_applied = 0;
  endfunction

  function automatic void m_step();
    bit beat, fend, apply;
    int base;
    beat  = bus.mon_tvalid && bus.mon_tready;
    base  = bus.mon_tuser ? 0 : m_line;
    fend  = beat && bus.mon_tlast && (base == LPF - 1);
    apply = m_pending && (m_mode != 2 || (!m_mid && !beat) || fend);
    m_applied = apply;
    if (apply) begin
      for (int i = 0; i < 9; i++) m_coeff[i] = m_stage[i];
      m_pending = 0;
    end else if (bus.commit) begin
      m_pending = 1;
    end
    if (bus.cfg_wr_en && bus.cfg_wr_addr < 9) m_stage[bus.cfg_wr_addr] = bus.cfg_wr_data;
    if (beat) begin
      m_idle = 0;
      m_mid  = 1;
      m_line = base;
      if (bus.mon_tlast) begin
        if (fend) begin m_line = 0; m_mid = 0; end
        else m_line = base + 1;
      end
    end else begin
      if (m_mid && m_idle == IT - 1) begin m_mid = 0; m_line = 0; m_stall = 1; end
      if (m_idle < IT - 1) m_idle++;
    end
    if (!bus.enable_req) m_mode = 0;
    else if (m_mode == 0) begin m_mode = 1; m_rcnt = 0; end
    else if (m_mode == 1) begin
      if (m_rcnt == RC - 1) m_mode = 2;
      else m_rcnt++;
    end
  endfunction

  // Compare process: DUT outputs of the current cycle vs model, then advance the model.
  always @(negedge clk) begin
    if (rst) m_reset();
    check("coeff_out", bus.coeff_out, pack9(m_coeff));
    check("core_enable", bus.core_enable, m_mode == 2);
    check("core_sw_reset", bus.core_sw_reset, m_mode != 2);
    check("pending", bus.pending, m_pending);
    check("applied", bus.applied, m_applied);
    check("stall_err", bus.stall_err, m_stall);
    if (!rst) m_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit user, input bit last);
    bus.mon_tvalid = 1'b1; bus.mon_tready = 1'b1;
    bus.mon_tuser  = user; bus.mon_tlast  = last;
    tick();
    bus.mon_tvalid = 1'b0; bus.mon_tuser = 1'b0; bus.mon_tlast = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [DW-1:0] data);
    bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = addr; bus.cfg_wr_data = data;
    tick();
    bus.cfg_wr_en = 1'b0;
  endtask

  task automatic cmt();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  logic [DW-1:0] lit [9];
  int idle_burst, off_len;

  initial begin
    bus.cfg_wr_en = 0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0; bus.commit = 0;
    bus.enable_req = 0; bus.mon_tvalid = 0; bus.mon_tready = 1; bus.mon_tuser = 0;
    bus.mon_tlast = 0;
    for (int i = 0; i < 9; i++) lit[i] = '0;
    lit[0] = ONE; lit[4] = ONE; lit[8] = ONE;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // T1: reset state
    check("t1_coeff_identity", bus.coeff_out, pack9(lit));
    check("t1_sw_reset", bus.core_sw_reset, 1'b1);
    check("t1_enable", bus.core_enable, 1'b0);
    check("t1_pending", bus.pending, 1'b0);

    // T2: soft reset held four cycles, then enable
    bus.enable_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_sw_reset_held", bus.core_sw_reset, 1'b1);
      check("t2_enable_low", bus.core_enable, 1'b0);
    end
    tick();
    check("t2_enable_on", bus.core_enable, 1'b1);
    check("t2_sw_reset_off", bus.core_sw_reset, 1'b0);

    // T3: idle stream, commit applies two cycles later
    wr(4'd2, 32'h0005_0000);
    cmt();
    check("t3_pending_set", bus.pending, 1'b1);
    check("t3_h13_old", bus.coeff_out[2*DW +: DW], 32'h0);
    tick();
    lit[2] = 32'h0005_0000;
    check("t3_h13_new", bus.coeff_out[2*DW +: DW], 32'h0005_0000);
    check("t3_applied", bus.applied, 1'b1);
    check("t3_pending_clr", bus.pending, 1'b0);
    check("t3_model_coeff", pack9(m_coeff), pack9(lit));
    tick();
    check("t3_applied_once", bus.applied, 1'b0);

    // T4: commit at line 100, applied on the 720th tlast beat
    send(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) send(1'b0, 1'b1);
    wr(4'd0, 32'h0002_0000);
    cmt();
    check("t4_pending", bus.pending, 1'b1);
    for (int i = 0; i < 619; i++) begin
      if (i == 300) wr(4'd3, 32'h0000_0777);
      send(1'b0, 1'b1);
    end
    check("t4_h11_held", bus.coeff_out[0 +: DW], ONE);
    check("t4_h21_held", bus.coeff_out[3*DW +: DW], 32'h0);
    check("t4_still_pending", bus.pending, 1'b1);
    send(1'b0, 1'b1);
    lit[0] = 32'h0002_0000; lit[3] = 32'h0000_0777;
    check("t4_coeff_new", bus.coeff_out, pack9(lit));
    check("t4_applied", bus.applied, 1'b1);

    // T5: mid-frame stall
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b0, 1'b1);
    wr(4'd1, 32'h0000_1234);
    cmt();
    repeat (IT - 3) tick();
    check("t5_no_stall_yet", bus.stall_err, 1'b0);
    tick();
    check("t5_stall", bus.stall_err, 1'b1);
    check("t5_pending", bus.pending, 1'b1);
    check("t5_h12_old", bus.coeff_out[1*DW +: DW], 32'h0);
    tick();
    lit[1] = 32'h0000_1234;
    check("t5_coeff_new", bus.coeff_out, pack9(lit));
    check("t5_applied", bus.applied, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    check("t5_stall_sticky", bus.stall_err, 1'b1);

    // T6: drop enable mid-frame, then async reset during soft reset
    wr(4'd7, 32'h0000_0042);
    cmt();
    check("t6_pending", bus.pending, 1'b1);
    bus.enable_req = 1'b0;
    tick();
    check("t6_off_enable", bus.core_enable, 1'b0);
    check("t6_off_sw_reset", bus.core_sw_reset, 1'b1);
    check("t6_h32_old", bus.coeff_out[7*DW +: DW], 32'h0);
    tick();
    check("t6_h32_new", bus.coeff_out[7*DW +: DW], 32'h0000_0042);
    check("t6_applied", bus.applied, 1'b1);
    bus.enable_req = 1'b1;
    tick();
    tick();
    check("t6_resetting", bus.core_sw_reset, 1'b1);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) lit[i] = (i % 4 == 0) ? ONE : '0;
    check("t6_rst_coeff", bus.coeff_out, pack9(lit));
    check("t6_rst_sw_reset", bus.core_sw_reset, 1'b1);
    check("t6_rst_enable", bus.core_enable, 1'b0);
    check("t6_rst_status", {bus.pending, bus.applied, bus.stall_err}, 3'b000);
    tick();
    tick();
    rst = 1'b0;

    // Randomized traffic checked against the model every cycle
    idle_burst = 0;
    off_len = 0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      if (idle_burst == 0 && $urandom_range(5999) == 0) idle_burst = IT + 80;
      if (off_len == 0 && $urandom_range(4999) == 0) off_len = int'($urandom_range(20, 1));
      bus.enable_req = (off_len == 0);
      if (off_len > 0) off_len--;
      bus.mon_tvalid = (idle_burst == 0) && ($urandom_range(3) != 0);
      if (idle_burst > 0) idle_burst--;
      bus.mon_tready  = ($urandom_range(3) != 0);
      bus.mon_tlast   = ($urandom_range(1) == 1);
      bus.mon_tuser   = !bus.mon_tlast && ($urandom_range(1999) == 0);
      bus.cfg_wr_en   = ($urandom_range(7) == 0);
      bus.cfg_wr_addr = 4'($urandom_range(15));
      bus.cfg_wr_data = $urandom;
      bus.commit      = ($urandom_range(39) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
